fixed_point_multiplier_seq: RTL and testbench



---
 rtl/fixed_point_multiplier_seq.sv | 97 +++++++++
 tb/tb_fixed_point_multiplier_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier_seq.sv
// Sequential sign-magnitude Q-format multiplier: one multiplier bit per cycle, LSB first.
// Result is valid N cycles after start is accepted; the result saturates on magnitude overflow.
module fixed_point_multiplier_seq #(
  parameter int N = 32,
  parameter int Q = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  output logic [N-1:0] product_out,
  output logic         complete,
  output logic         overflow
);

  localparam int M  = N - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(M);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc;
  logic [AW-1:0] a_shift;
  logic [M-1:0]  b_shift;
  logic          sign;
  logic [CW-1:0] cnt;

  logic          fin_ovf;
  logic [M-1:0]  fin_mag;
  logic          fin_sign;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (start) state_nxt = MULT;
      default: state_nxt = IDLE;
    endcase
  end

  // Finalize: drop Q fraction bits, saturate if anything survives above the magnitude field.
  always_comb begin
    fin_ovf  = |acc[AW-1:Q+M];
    fin_mag  = fin_ovf ? {M{1'b1}} : acc[Q+M-1:Q];
    fin_sign = sign & (|fin_mag);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      a_shift     <= '0;
      b_shift     <= '0;
      sign        <= 1'b0;
      cnt         <= '0;
      product_out <= '0;
      complete    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_shift  <= {{(AW-M){1'b0}}, multiplicand[M-1:0]};
            b_shift  <= multiplier[M-1:0];
            sign     <= multiplicand[N-1] ^ multiplier[N-1];
            acc      <= '0;
            cnt      <= '0;
            complete <= 1'b0;
            overflow <= 1'b0;
          end
        end
        MULT: begin
          if (cnt != LAST) begin
            if (b_shift[0]) acc <= acc + a_shift;
            a_shift <= a_shift << 1;
            b_shift <= b_shift >> 1;
            cnt     <= cnt + 1'b1;
          end else begin
            product_out <= {fin_sign, fin_mag};
            overflow    <= fin_ovf;
            complete    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier_seq.sv
// Randomized and directed checks of fixed_point_multiplier_seq against an arithmetic reference model.
module tb_fixed_point_multiplier_seq;

  localparam int N = 32;
  localparam int Q = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  multiplicand;
  logic [N-1:0]  multiplier;
  logic [N-1:0]  product_out;
  logic          complete;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  fixed_point_multiplier_seq #(.N(N), .Q(Q)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product_out  (product_out),
    .complete     (complete),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Real-number semantics: |a|*|b| / 2^Q truncated, saturated, no negative zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output logic o);
    longint unsigned ma, mb, prod, sh, mag;
    ma   = longint'(a[30:0]);
    mb   = longint'(b[30:0]);
    prod = ma * mb;
    sh   = prod >> Q;
    o    = (sh > 64'h7FFF_FFFF);
    mag  = o ? 64'h7FFF_FFFF : sh;
    p    = {((a[31] ^ b[31]) && (mag != 0)), mag[30:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom >> $urandom_range(0, 31);
    r[31] = $urandom_range(0, 1) == 1;
    return r;
  endfunction

  // pulse_at: cycle of MULT with a spurious start; rst_at: cycle with reset asserted (-1 = none).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input int rst_at, input string tag);
    logic [31:0] ep;
    logic        eo;
    model(a, b, ep, eo);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    for (int k = 1; k <= N; k++) begin
      if (k == pulse_at) start = 1'b1;
      if (k == rst_at)   rst_n = 1'b0;
      @(posedge clk);
      #1;
      if (k == rst_at) begin
        check({tag, " rst complete"}, 64'(complete), 64'd0);
        check({tag, " rst product"}, 64'(product_out), 64'd0);
        check({tag, " rst overflow"}, 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == N - 1) check({tag, " early complete"}, 64'(complete), 64'd0);
      if (k == N) begin
        check({tag, " complete"}, 64'(complete), 64'd1);
        check({tag, " product"}, 64'(product_out), 64'(ep));
        check({tag, " overflow"}, 64'(overflow), 64'(eo));
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic [31:0] ep;
    logic        eo;

    rst_n        = 1'b0;
    start        = 1'b1;
    multiplicand = 32'h0000_0014;
    multiplier   = 32'h0000_0018;
    repeat (3) @(posedge clk);
    #1;
    check("reset complete", 64'(complete), 64'd0);
    check("reset product", 64'(product_out), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    run_op(32'h0000_0014, 32'h0000_0018, -1, -1, "pos x pos");
    run_op(32'h8000_0014, 32'h0000_0018, -1, -1, "neg x pos");
    run_op(32'h8000_0014, 32'h8000_0018, -1, -1, "neg x neg");
    run_op(32'h8000_0001, 32'h0000_0001, -1, -1, "neg zero");
    run_op(32'h7FFF_FFFF, 32'h8000_0010, -1, -1, "saturate");
    run_op(32'h0000_0000, 32'h8123_4567, -1, -1, "zero operand");
    run_op(32'h0000_0014, 32'h0000_0018, 10, -1, "ignored start");
    run_op(32'h0000_0014, 32'h0000_0018, -1, 15, "abort");
    run_op(32'h8000_0028, 32'h0000_0030, -1, -1, "after abort");

    for (int i = 0; i < 10; i++) begin
      run_op(rand_operand(), rand_operand(), -1, -1, "random");
    end

    // Back-to-back with start held high across three operations.
    ba[0] = 32'h0000_0014; bb[0] = 32'h0000_0018;
    ba[1] = rand_operand(); bb[1] = rand_operand();
    ba[2] = 32'h7FFF_FFFF; bb[2] = 32'h8000_0010;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = ba[0];
    multiplier   = bb[0];
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        multiplicand = ba[i+1];
        multiplier   = bb[i+1];
      end else begin
        start = 1'b0;
      end
      repeat (N - 1) @(posedge clk);
      #1;
      check("b2b early complete", 64'(complete), 64'd0);
      @(posedge clk);
      #1;
      model(ba[i], bb[i], ep, eo);
      check("b2b complete", 64'(complete), 64'd1);
      check("b2b product", 64'(product_out), 64'(ep));
      check("b2b overflow", 64'(overflow), 64'(eo));
      if (i < 2) begin
        @(posedge clk);
        #1;
        check("b2b drop", 64'(complete), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    check("b2b hold complete", 64'(complete), 64'd1);
    check("b2b hold product", 64'(product_out), 64'(ep));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
